// File: rtl/priority_grant_arbiter.sv
// priority_grant_arbiter: fixed-priority 4-way arbiter with a registered one-hot grant and a one-cycle gap after each release
// Ports: clk; reset_n (async, active-low); req[3:0] = {A,B,C,D}, A highest; done (release from holder);
//        gnt[3:0] one-hot grant; idx[1:0] encoded grant (A=11..D=00); busy (grant active); timeout (revocation pulse).
// Optional ARB_TIMEOUT_EN: a grant held MAX_HOLD cycles is revoked, and the revoked requester sits out one arbitration.
module priority_grant_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] idx,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE = 2'b00, GRANT = 2'b01, GAP = 2'b10, BAD = 2'b11} state_t;
  state_t state, state_nx;
  logic [3:0] elig, gnt_nx;
  logic [1:0] idx_nx;
  logic busy_nx, timeout_nx, release_c, expire;
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("MAX_HOLD must be in 2..255");
  end
  // gnt is one-hot while granting, so this picks out the holder's own request bit
  assign release_c = done | ~|(req & gnt);
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] hold_last = 8'(MAX_HOLD - 1);
  logic [3:0] mask, mask_nx;
  logic [7:0] cnt, cnt_nx;
  assign elig = req & ~mask;
  assign expire = cnt == hold_last;
  // mask is set on revocation, survives the gap, and is dropped by whatever IDLE does next
  always_comb begin
    mask_nx = (state == GRANT && !release_c && expire) ? gnt : (state == GAP) ? mask : 4'b0000;
    cnt_nx = (state == GRANT) ? cnt + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= 4'b0000;
      cnt <= 8'd0;
    end else begin
      mask <= mask_nx;
      cnt <= cnt_nx;
    end
  end
`else
  assign elig = req;
  assign expire = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    gnt_nx = gnt;
    idx_nx = idx;
    busy_nx = busy;
    timeout_nx = 1'b0;
    case (state)
      IDLE: if (|elig) begin
        state_nx = GRANT;
        busy_nx = 1'b1;
        gnt_nx = elig[3] ? 4'b1000 : elig[2] ? 4'b0100 : elig[1] ? 4'b0010 : 4'b0001;
        idx_nx = elig[3] ? 2'd3 : elig[2] ? 2'd2 : elig[1] ? 2'd1 : 2'd0;
      end
      // release has priority over a coincident expiry
      GRANT: if (release_c || expire) begin
        state_nx = GAP;
        gnt_nx = 4'b0000;
        idx_nx = 2'd0;
        busy_nx = 1'b0;
        timeout_nx = !release_c;
      end
      GAP: state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        gnt_nx = 4'b0000;
        idx_nx = 2'd0;
        busy_nx = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt <= 4'b0000;
      idx <= 2'd0;
      busy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      idx <= idx_nx;
      busy <= busy_nx;
      timeout <= timeout_nx;
    end
  end
endmodule

// File: tb/tb_priority_grant_arbiter.sv
// tb_priority_grant_arbiter: directed and randomized checks of priority_grant_arbiter against a behavioural model
module tb_priority_grant_arbiter;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit to_en = 1'b1;
`else
  localparam bit to_en = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, done = 1'b0;
  logic [3:0] req = 4'b0000, gnt;
  logic [1:0] idx;
  logic busy, timeout;
  int n_cmp = 0, n_bad = 0;
  int m_holder = -1, m_cool = 0, m_masked = -1, m_held = 0;
  logic m_to = 1'b0;
  priority_grant_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .gnt(gnt), .idx(idx), .busy(busy), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] exp_out();
    logic [3:0] g;
    logic [1:0] x;
    g = (m_holder >= 0) ? 4'(1 << m_holder) : 4'b0000;
    x = (m_holder >= 0) ? 2'(m_holder) : 2'd0;
    return {g, x, m_holder >= 0, m_to};
  endfunction
  task automatic model_reset();
    m_holder = -1; m_cool = 0; m_masked = -1; m_held = 0; m_to = 1'b0;
  endtask
  // one clock edge of the arbitration rules: hold until release/expiry, one gap cycle, then highest unmasked request
  task automatic model_edge(input logic [3:0] r, input logic d);
    m_to = 1'b0;
    if (m_holder >= 0) begin
      if (d || !r[m_holder]) begin
        m_holder = -1; m_cool = 1;
      end else if (to_en && m_held == MAX_HOLD - 1) begin
        m_masked = m_holder; m_holder = -1; m_cool = 1; m_to = 1'b1;
      end else m_held++;
    end else if (m_cool != 0) m_cool = 0;
    else begin
      for (int i = 3; i >= 0; i--)
        if (m_holder < 0 && r[i] && i != m_masked) begin
          m_holder = i; m_held = 0;
        end
      m_masked = -1;
    end
  endtask
  task automatic cycle(input logic [3:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0; req = 4'b1111; model_reset();
    @(negedge clk);
    n_cmp++;
    if ({gnt, idx, busy, timeout} !== 8'b0) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", {gnt, idx, busy, timeout}, 8'b0);
    end
    reset_n = 1'b1;
    cycle(4'b1111, 1'b0);
    n_cmp++;
    if ({gnt, idx, busy, timeout} !== 8'b1000_11_1_0) begin
      n_bad++; $display("FAIL first_arb: got %b want %b", {gnt, idx, busy, timeout}, 8'b1000_11_1_0);
    end
  endtask
  task automatic test_no_preempt();
    logic [12:0] t [5] = '{{4'b0000, 1'b0, 8'b0000_00_0_0}, {4'b0000, 1'b0, 8'b0000_00_0_0},
                           {4'b0011, 1'b0, 8'b0010_01_1_0}, {4'b1011, 1'b0, 8'b0010_01_1_0},
                           {4'b1011, 1'b0, 8'b0010_01_1_0}};
    for (int i = 0; i < 5; i++) begin
      cycle(t[i][12:9], t[i][8]);
      n_cmp++;
      if ({gnt, idx, busy, timeout} !== t[i][7:0]) begin
        n_bad++; $display("FAIL no_preempt[%0d]: got %b want %b", i, {gnt, idx, busy, timeout}, t[i][7:0]);
      end
    end
  endtask
  task automatic test_release_done();
    logic [12:0] t [3] = '{{4'b1111, 1'b1, 8'b0000_00_0_0}, {4'b1111, 1'b0, 8'b0000_00_0_0},
                           {4'b1111, 1'b0, 8'b1000_11_1_0}};
    for (int i = 0; i < 3; i++) begin
      cycle(t[i][12:9], t[i][8]);
      n_cmp++;
      if ({gnt, idx, busy, timeout} !== t[i][7:0]) begin
        n_bad++; $display("FAIL release_done[%0d]: got %b want %b", i, {gnt, idx, busy, timeout}, t[i][7:0]);
      end
    end
  endtask
  task automatic test_drop_req();
    logic [12:0] t [6] = '{{4'b0000, 1'b0, 8'b0000_00_0_0}, {4'b0000, 1'b0, 8'b0000_00_0_0},
                           {4'b0100, 1'b0, 8'b0100_10_1_0}, {4'b0000, 1'b0, 8'b0000_00_0_0},
                           {4'b0000, 1'b1, 8'b0000_00_0_0}, {4'b0100, 1'b1, 8'b0100_10_1_0}};
    for (int i = 0; i < 6; i++) begin
      cycle(t[i][12:9], t[i][8]);
      n_cmp++;
      if ({gnt, idx, busy, timeout} !== t[i][7:0]) begin
        n_bad++; $display("FAIL drop_req[%0d]: got %b want %b", i, {gnt, idx, busy, timeout}, t[i][7:0]);
      end
    end
  endtask
  task automatic test_async_reset();
    logic [12:0] t [3] = '{{4'b0000, 1'b0, 8'b0000_00_0_0}, {4'b0000, 1'b0, 8'b0000_00_0_0},
                           {4'b0001, 1'b0, 8'b0001_00_1_0}};
    for (int i = 0; i < 3; i++) begin
      cycle(t[i][12:9], t[i][8]);
      n_cmp++;
      if ({gnt, idx, busy, timeout} !== t[i][7:0]) begin
        n_bad++; $display("FAIL async_setup[%0d]: got %b want %b", i, {gnt, idx, busy, timeout}, t[i][7:0]);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({gnt, idx, busy, timeout} !== 8'b0) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", {gnt, idx, busy, timeout}, 8'b0);
    end
    #1;
    reset_n = 1'b1;
    cycle(4'b0001, 1'b0);
    n_cmp++;
    if ({gnt, idx, busy, timeout} !== 8'b0001_00_1_0) begin
      n_bad++; $display("FAIL post_reset_arb: got %b want %b", {gnt, idx, busy, timeout}, 8'b0001_00_1_0);
    end
  endtask
`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [12:0] t [12] = '{{4'b0000, 1'b0, 8'b0000_00_0_0}, {4'b0000, 1'b0, 8'b0000_00_0_0},
                            {4'b1100, 1'b0, 8'b1000_11_1_0}, {4'b1100, 1'b0, 8'b1000_11_1_0},
                            {4'b1100, 1'b0, 8'b1000_11_1_0}, {4'b1100, 1'b0, 8'b1000_11_1_0},
                            {4'b1100, 1'b0, 8'b0000_00_0_1}, {4'b1100, 1'b0, 8'b0000_00_0_0},
                            {4'b1100, 1'b0, 8'b0100_10_1_0}, {4'b1000, 1'b0, 8'b0000_00_0_0},
                            {4'b1000, 1'b0, 8'b0000_00_0_0}, {4'b1000, 1'b0, 8'b1000_11_1_0}};
    for (int i = 0; i < 12; i++) begin
      cycle(t[i][12:9], t[i][8]);
      n_cmp++;
      if ({gnt, idx, busy, timeout} !== t[i][7:0]) begin
        n_bad++; $display("FAIL timeout[%0d]: got %b want %b", i, {gnt, idx, busy, timeout}, t[i][7:0]);
      end
    end
  endtask
`else
  task automatic test_long_hold();
    for (int i = 0; i < 12; i++) begin
      cycle(4'b1111, 1'b0);
      n_cmp++;
      if ({gnt, idx, busy, timeout} !== 8'b0001_00_1_0) begin
        n_bad++; $display("FAIL long_hold[%0d]: got %b want %b", i, {gnt, idx, busy, timeout}, 8'b0001_00_1_0);
      end
    end
  endtask
`endif
  task automatic test_random();
    logic [3:0] r;
    logic d;
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 99) < 15);
      cycle(r, d);
      n_cmp++;
      if ({gnt, idx, busy, timeout} !== exp_out()) begin
        n_bad++; $display("FAIL random[%0d]: req=%b done=%b got %b want %b", i, r, d, {gnt, idx, busy, timeout}, exp_out());
      end
    end
  endtask
  initial begin
    test_reset();
    test_no_preempt();
    test_release_done();
    test_drop_req();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
